alu_mod_seq: RTL and testbench
==============================

ALU_MOD_SEQ -- requirements
Module: alu_mod_seq

Interface
REQ-001 N  32  datapath width, shared with alu.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  request to compute a_i mod m_i; sampled only in IDLE.
REQ-005 abort_i  in  1  cancel operation in progress.
REQ-006 a_i, m_i  in  N each  dividend and modulus, unsigned; captured on accepted start.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 done_o  out  1  one-cycle completion pulse.
REQ-009 err_o  out  1  modulus-zero flag, valid with done_o, held until next accepted start.
REQ-010 result_o, quotient_o  out  N each  remainder and subtraction count, held until next accepted start.
REQ-011 alu_opcode_o  out  3; alu_a_o, alu_b_o  out  N each  drive the shared alu.
REQ-012 alu_result_i  in  N; alu_flags_i  in  4  alu outputs: [3]=N, [2]=Z, [1]=C (1 = no borrow on SUB), [0]=V.

Function
REQ-013 States: IDLE, SUB, DONE; state register is the only control state.
REQ-014 IDLE: start_i=1, abort_i=0, m_i!=0 -> SUB; acc<=a_i, mod<=m_i, quotient<=0, err<=0.
REQ-015 IDLE: start_i=1, abort_i=0, m_i=0 -> DONE; acc<=a_i, quotient<=0, err<=1.
REQ-016 IDLE: start_i=1 with abort_i=1 -> stays IDLE; abort wins.
REQ-017 SUB: alu_opcode_o=SUB (001), alu_a_o=acc, alu_b_o=mod, every cycle.
REQ-018 SUB, C=1: acc<=alu_result_i, quotient<=quotient+1, stay in SUB.
REQ-019 SUB, C=0: acc and quotient unchanged, -> DONE.
REQ-020 SUB, abort_i=1: -> IDLE regardless of C; no done_o pulse; result_o and quotient_o hold their partial values; err_o=0.
REQ-021 DONE: done_o=1 for exactly one cycle, result_o=acc, quotient_o=quotient, then -> IDLE unconditionally; abort_i ignored.
REQ-022 start_i while busy_o=1 is ignored, not queued.
REQ-023 Latency, start sampled at edge 0: done_o high in cycle q+2 (q = floor(a/m)); m=0 case high in cycle 1.
REQ-024 quotient counter is N bits; no overflow is possible since m>=1.
REQ-025 IDLE and DONE: alu_opcode_o=MOV (100), alu_a_o=0, alu_b_o=0.
REQ-026 result_o and quotient_o are registered; alu outputs are combinational from state and acc/mod only.

Reset
REQ-027 rst_ni low -> state=IDLE; acc, mod, quotient, result_o, quotient_o = 0; err_o=0, done_o=0, busy_o=0; effective immediately, mid-operation included.
REQ-028 After rst_ni release, the first accepted start is on the first rising edge with start_i=1.

Structure
REQ-029 Shared package alu_pkg holds the N default, opcode constants (ADD 000, SUB 001, AND 010, OR 011, MOV 100) and flag bit indices.
REQ-030 Single flat module; the alu is instantiated beside it, not inside; no sub-module.
REQ-031 State encoding is an enum local to the module.

Verification
REQ-032 a=100, m=7 -> done_o in cycle 16, result_o=2, quotient_o=14, err_o=0; alu_opcode_o=SUB in cycles 1..15.
REQ-033 a=5, m=9 -> done_o in cycle 2, result_o=5, quotient_o=0.
REQ-034 a=7, m=7 -> done_o in cycle 3, result_o=0, quotient_o=1.
REQ-035 a=40, m=0 -> done_o in cycle 1, err_o=1, result_o=40, quotient_o=0.
REQ-036 a=100, m=7, abort_i in cycle 4 -> busy_o low from cycle 5, no done_o; new start a=9, m=4 -> result_o=1, quotient_o=2.
REQ-037 rst_ni low in cycle 3 of a=100, m=7 -> all outputs 0 at once; start held during busy has no effect.

Source files
------------

// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and the sequencers that drive it:
// datapath width, opcode encodings and flag bit positions.
package alu_pkg;

    localparam int unsigned ALU_N = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_mod_seq.sv
// Sequencer computing a mod m by repeated subtraction on the shared ALU.
// The remainder and the subtraction count are reported on completion or abort.
module alu_mod_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_N
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] m_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [N-1:0] result_o,
    output logic [N-1:0] quotient_o,
    output logic [2:0]   alu_opcode_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    input  logic [N-1:0] alu_result_i,
    input  logic [3:0]   alu_flags_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SUB  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mod_q, mod_d;
    logic [N-1:0] quot_q, quot_d;
    logic         err_q, err_d;
    logic         done_q;
    logic         busy_q;
    logic         no_borrow_s;
    logic         unused_flags_s;

    assign no_borrow_s    = alu_flags_i[FLAG_C];
    assign unused_flags_s = ^{alu_flags_i[FLAG_N], alu_flags_i[FLAG_Z], alu_flags_i[FLAG_V]};

    // Next-state and datapath update selection.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mod_d   = mod_q;
        quot_d  = quot_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    acc_d  = a_i;
                    quot_d = {N{1'b0}};
                    if (m_i == {N{1'b0}}) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mod_d   = m_i;
                        err_d   = 1'b0;
                        state_d = S_SUB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SUB: begin
                // Abort wins over an in-flight subtraction: the partial values stay visible.
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (no_borrow_s) begin
                    acc_d  = alu_result_i;
                    quot_d = quot_q + N'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= {N{1'b0}};
            mod_q   <= {N{1'b0}};
            quot_q  <= {N{1'b0}};
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mod_q   <= mod_d;
            quot_q  <= quot_d;
            err_q   <= err_d;
            done_q  <= (state_d == S_DONE);
            busy_q  <= (state_d != S_IDLE);
        end
    end

    // Shared-ALU drive: subtract only while iterating, otherwise a harmless MOV of zero.
    always_comb begin
        alu_opcode_o = OP_MOV;
        alu_a_o      = {N{1'b0}};
        alu_b_o      = {N{1'b0}};
        case (state_q)
            S_SUB: begin
                alu_opcode_o = OP_SUB;
                alu_a_o      = acc_q;
                alu_b_o      = mod_q;
            end
            default: begin
                alu_opcode_o = OP_MOV;
                alu_a_o      = {N{1'b0}};
                alu_b_o      = {N{1'b0}};
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign result_o   = acc_q;
    assign quotient_o = quot_q;

endmodule

// File: tb/tb_alu_mod_seq.sv
// Randomized and directed bench for alu_mod_seq with a behavioural ALU beside it
// and a reference model based on plain division.
module tb_alu_mod_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        abort_i;
    logic [31:0] a_i;
    logic [31:0] m_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] result_o;
    logic [31:0] quotient_o;
    logic [2:0]  alu_opcode_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i;
    logic [3:0]  alu_flags_i;

    int checks   = 0;
    int failures = 0;

    alu_mod_seq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .a_i          (a_i),
        .m_i          (m_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .result_o     (result_o),
        .quotient_o   (quotient_o),
        .alu_opcode_o (alu_opcode_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .alu_flags_i  (alu_flags_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural shared ALU: C is "no borrow" for SUB.
    always_comb begin
        alu_result_i = 32'd0;
        alu_flags_i  = 4'd0;
        case (alu_opcode_o)
            3'b000:  alu_result_i = alu_a_o + alu_b_o;
            3'b001:  alu_result_i = alu_a_o - alu_b_o;
            3'b010:  alu_result_i = alu_a_o & alu_b_o;
            3'b011:  alu_result_i = alu_a_o | alu_b_o;
            3'b100:  alu_result_i = alu_a_o;
            default: alu_result_i = 32'd0;
        endcase
        alu_flags_i[3] = alu_result_i[31];
        alu_flags_i[2] = (alu_result_i == 32'd0);
        alu_flags_i[1] = (alu_opcode_o == 3'b001) ? (alu_a_o >= alu_b_o) : 1'b0;
        alu_flags_i[0] = 1'b0;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation: abort_at = cycle number with abort_i high (0 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] m, input int abort_at);
        logic [31:0] exp_q, exp_r;
        int          lat, busy_end, sub_end, hold, done_cyc, done_cnt;
        int          busy_bad, opc_bad, opnd_bad;
        bit          aborted;
        exp_q    = (m != 32'd0) ? a / m : 32'd0;
        exp_r    = (m != 32'd0) ? a % m : a;
        lat      = (m != 32'd0) ? int'(exp_q) + 2 : 1;
        aborted  = (m != 32'd0) && (abort_at >= 1) && (abort_at <= int'(exp_q) + 1);
        if (aborted) begin
            exp_q = 32'(abort_at - 1);
            exp_r = a - exp_q * m;
        end
        busy_end = aborted ? abort_at : lat;
        sub_end  = (m == 32'd0) ? 0 : (aborted ? abort_at : lat - 1);
        hold     = (busy_end < 3) ? busy_end : 3;
        done_cyc = 0;
        done_cnt = 0;
        busy_bad = 0;
        opc_bad  = 0;
        opnd_bad = 0;

        @(negedge clk_i);
        start_i = 1'b1;
        abort_i = 1'b0;
        a_i     = a;
        m_i     = m;
        @(posedge clk_i);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
                check_eq("result_at_done", result_o, exp_r);
                check_eq("quot_at_done", quotient_o, exp_q);
                check_eq("err_at_done", err_o, (m == 32'd0));
            end
            if (busy_o !== (k <= busy_end)) busy_bad++;
            if (k <= sub_end) begin
                if (alu_opcode_o !== 3'b001) opc_bad++;
                if (alu_a_o !== a - 32'(k - 1) * m || alu_b_o !== m) opnd_bad++;
            end else begin
                if (alu_opcode_o !== 3'b100 || alu_a_o !== 32'd0 || alu_b_o !== 32'd0) opc_bad++;
            end
            start_i = (k <= hold);
            a_i     = $urandom;
            m_i     = $urandom;
            abort_i = (k == abort_at);
            @(posedge clk_i);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        check_eq("done_count", done_cnt, aborted ? 0 : 1);
        check_eq("done_cycle", done_cyc, aborted ? 0 : lat);
        check_eq("busy_profile", busy_bad, 0);
        check_eq("alu_opcode", opc_bad, 0);
        check_eq("alu_operands", opnd_bad, 0);
        check_eq("result_held", result_o, exp_r);
        check_eq("quot_held", quotient_o, exp_q);
        check_eq("err_held", err_o, (m == 32'd0) && !aborted);
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        a_i     = 32'd0;
        m_i     = 32'd0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_result", result_o, 0);
        check_eq("rst_quot", quotient_o, 0);
        check_eq("rst_opcode", alu_opcode_o, 3'b100);
        rst_ni = 1'b1;

        run_op(32'd100, 32'd7, 0);
        run_op(32'd5, 32'd9, 0);
        run_op(32'd7, 32'd7, 0);
        run_op(32'd40, 32'd0, 0);
        run_op(32'd100, 32'd7, 4);
        run_op(32'd9, 32'd4, 0);
        run_op(32'd0, 32'd3, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Reset asserted mid-operation while start is held high.
        @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'd100;
        m_i     = 32'd7;
        @(posedge clk_i);
        repeat (2) begin
            @(negedge clk_i);
            a_i = 32'd1;
            m_i = 32'd1;
        end
        @(negedge clk_i);
        check_eq("pre_rst_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy_o, 0);
        check_eq("mid_rst_done", done_o, 0);
        check_eq("mid_rst_err", err_o, 0);
        check_eq("mid_rst_result", result_o, 0);
        check_eq("mid_rst_quot", quotient_o, 0);
        check_eq("mid_rst_opcode", alu_opcode_o, 3'b100);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op(32'd9, 32'd4, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rm;
            int          ab, q;
            ra = $urandom_range(0, 300);
            rm = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
            q  = (rm != 32'd0) ? int'(ra / rm) : 0;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, q + 3) : 0;
            run_op(ra, rm, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
